// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch command front end: sequencer states,
// digit selector, BCD digit limits, command priority and the preset increment rule.
package stopwatch_pkg;

  // Edit states are consecutive so that a set press advances by +1, ending in COMMIT_START.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_EDIT_MS_HR   = 3'd1,
    ST_EDIT_LS_HR   = 3'd2,
    ST_EDIT_MS_MIN  = 3'd3,
    ST_EDIT_LS_MIN  = 3'd4,
    ST_COMMIT_START = 3'd5,
    ST_COMMIT_LOAD  = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    DIG_MS_HR  = 2'd0,
    DIG_LS_HR  = 2'd1,
    DIG_MS_MIN = 2'd2,
    DIG_LS_MIN = 2'd3
  } set_digit_t;

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } preset_t;

  localparam logic [3:0] LIM_MS_HR    = 4'd2;
  localparam logic [3:0] LIM_LS_HR    = 4'd9;
  localparam logic [3:0] LIM_LS_HR_20 = 4'd3;
  localparam logic [3:0] LIM_MS_MIN   = 4'd5;
  localparam logic [3:0] LIM_LS_MIN   = 4'd9;

  // Command bit positions; a lower index wins arbitration.
  localparam int BTN_START = 0;
  localparam int BTN_LAP   = 1;
  localparam int BTN_STOP  = 2;
  localparam int BTN_CLR   = 3;
  localparam int NUM_CMD   = 4;

  function automatic logic [NUM_CMD-1:0] first_press(logic [NUM_CMD-1:0] p);
    return p & (~p + NUM_CMD'(1));
  endfunction

  function automatic logic is_edit(seq_state_t s);
    return s inside {ST_EDIT_MS_HR, ST_EDIT_LS_HR, ST_EDIT_MS_MIN, ST_EDIT_LS_MIN};
  endfunction

  function automatic set_digit_t digit_of(seq_state_t s);
    case (s)
      ST_EDIT_LS_HR:  return DIG_LS_HR;
      ST_EDIT_MS_MIN: return DIG_MS_MIN;
      ST_EDIT_LS_MIN: return DIG_LS_MIN;
      default:        return DIG_MS_HR;
    endcase
  endfunction

  function automatic logic [3:0] wrap_inc(logic [3:0] d, logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  // Keeps the preset inside 00:00-23:59 whichever digit is bumped.
  function automatic preset_t inc_digit(preset_t p, set_digit_t sel);
    preset_t r = p;
    case (sel)
      DIG_MS_HR: begin
        r.ms_hr = wrap_inc(p.ms_hr, LIM_MS_HR);
        if (r.ms_hr == LIM_MS_HR && p.ls_hr > LIM_LS_HR_20) r.ls_hr = 4'd0;
      end
      DIG_LS_HR:  r.ls_hr  = wrap_inc(p.ls_hr, (p.ms_hr == LIM_MS_HR) ? LIM_LS_HR_20 : LIM_LS_HR);
      DIG_MS_MIN: r.ms_min = wrap_inc(p.ms_min, LIM_MS_MIN);
      default:    r.ls_min = wrap_inc(p.ls_min, LIM_LS_MIN);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_cmd_ctrl_if.sv
// Command/preset bundle between the button front end (master) and the stopwatch core (slave).
interface stopwatch_cmd_ctrl_if;
  import stopwatch_pkg::*;

  logic       start;
  logic       lap;
  logic       stop;
  logic       clr;
  logic       load;
  logic [3:0] load_ms_hr;
  logic [3:0] load_ls_hr;
  logic [3:0] load_ms_min;
  logic [3:0] load_ls_min;
  logic       set_mode;
  set_digit_t set_digit;

  modport master (
    output start, lap, stop, clr, load,
    output load_ms_hr, load_ls_hr, load_ms_min, load_ls_min,
    output set_mode, set_digit
  );

  modport slave (
    input start, lap, stop, clr, load,
    input load_ms_hr, load_ls_hr, load_ms_min, load_ls_min,
    input set_mode, set_digit
  );
endinterface

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchroniser, stable-count debouncer and rising-edge press detect.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_CNT_W        = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  logic                sync_q1;
  logic                sync_q2;
  logic                level;
  logic                level_d;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      level_d <= level;
      // Any agreeing cycle restarts the count, so only an unbroken run flips the level.
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_d;
endmodule

// File: rtl/stopwatch_cmd_ctrl.sv
// Stopwatch front end: debounced buttons become single-cycle commands; HH:MM preset entry
// with start-then-load commit is built only when STOPWATCH_SET_EN is defined.
module stopwatch_cmd_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_CNT_W        = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_start,
  input  logic                 btn_lap,
  input  logic                 btn_stop,
  input  logic                 btn_clr,
  input  logic                 btn_set,
  input  logic                 btn_inc,
  stopwatch_cmd_ctrl_if.master cmd
);
  logic [NUM_CMD-1:0] btn_cmd;
  logic [NUM_CMD-1:0] press_cmd;
  logic [NUM_CMD-1:0] pulse;
  logic [NUM_CMD-1:0] pulse_nxt;
  logic               press_set;
  logic               press_inc;
  seq_state_t         state;
  seq_state_t         state_nxt;
  preset_t            preset;
  preset_t            preset_nxt;
  logic               load_q;
  logic               load_nxt;
  logic               set_mode_q;
  set_digit_t         set_digit_q;

  assign btn_cmd[BTN_START] = btn_start;
  assign btn_cmd[BTN_LAP]   = btn_lap;
  assign btn_cmd[BTN_STOP]  = btn_stop;
  assign btn_cmd[BTN_CLR]   = btn_clr;

  for (genvar i = 0; i < NUM_CMD; i++) begin : g_cmd_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W)) u_db (
      .clk(clk), .rst_n(rst_n), .btn(btn_cmd[i]), .press(press_cmd[i])
    );
  end

`ifdef STOPWATCH_SET_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W)) u_db_set (
    .clk(clk), .rst_n(rst_n), .btn(btn_set), .press(press_set)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .btn(btn_inc), .press(press_inc)
  );
`else
  // Without a set press the sequencer never leaves IDLE and the preset stays at zero.
  logic unused_entry_btns;
  assign unused_entry_btns = btn_set ^ btn_inc;
  assign press_set = 1'b0;
  assign press_inc = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    pulse_nxt  = '0;
    preset_nxt = preset;
    load_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        pulse_nxt = first_press(press_cmd);
        if (press_set) state_nxt = ST_EDIT_MS_HR;
      end
      ST_EDIT_MS_HR, ST_EDIT_LS_HR, ST_EDIT_MS_MIN, ST_EDIT_LS_MIN: begin
        if (press_cmd[BTN_CLR]) begin
          state_nxt = ST_IDLE;
        end else begin
          if (press_inc) preset_nxt = inc_digit(preset, digit_of(state));
          if (press_set) state_nxt = seq_state_t'(state + 3'd1);
        end
      end
      ST_COMMIT_START: state_nxt = ST_COMMIT_LOAD;
      default:         state_nxt = ST_IDLE;
    endcase
    // The core samples load only in RUN, which it enters one edge after start.
    if (state_nxt == ST_COMMIT_START) pulse_nxt[BTN_START] = 1'b1;
    if (state_nxt == ST_COMMIT_LOAD)  load_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pulse       <= '0;
      load_q      <= 1'b0;
      preset      <= '0;
      set_mode_q  <= 1'b0;
      set_digit_q <= DIG_MS_HR;
    end else begin
      state       <= state_nxt;
      pulse       <= pulse_nxt;
      load_q      <= load_nxt;
      preset      <= preset_nxt;
      set_mode_q  <= is_edit(state_nxt);
      set_digit_q <= digit_of(state_nxt);
    end
  end

  assign cmd.start       = pulse[BTN_START];
  assign cmd.lap         = pulse[BTN_LAP];
  assign cmd.stop        = pulse[BTN_STOP];
  assign cmd.clr         = pulse[BTN_CLR];
  assign cmd.load        = load_q;
  assign cmd.load_ms_hr  = preset.ms_hr;
  assign cmd.load_ls_hr  = preset.ls_hr;
  assign cmd.load_ms_min = preset.ms_min;
  assign cmd.load_ls_min = preset.ls_min;
  assign cmd.set_mode    = set_mode_q;
  assign cmd.set_digit   = set_digit_q;
endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Bench for stopwatch_cmd_ctrl: directed table, hand-written sequences and random buttons,
// all cross-checked every cycle against a history-based reference model.
module tb_stopwatch_cmd_ctrl;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] raw;   // 0 start, 1 lap, 2 stop, 3 clr, 4 set, 5 inc

  stopwatch_cmd_ctrl_if sw ();

  stopwatch_cmd_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(raw[0]), .btn_lap(raw[1]), .btn_stop(raw[2]), .btn_clr(raw[3]),
    .btn_set(raw[4]), .btn_inc(raw[5]),
    .cmd(sw.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_cmd[4];
  int n_load;
  int start_cyc, load_cyc;

  // Reference model: sync pipeline, last-D sync history, phase 0 idle / 1..4 edit / 5,6 commit.
  logic [5:0]   m_s1, m_s2, m_lvl, m_press;
  logic [D-1:0] m_hist [6];
  int           m_phase;
  int           m_dig [4];
  logic [3:0]   m_pulse;
  logic         m_load;

  typedef struct packed {
    logic [5:0] btns;
    logic [7:0] hold;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_inc(input int idx);
    case (idx)
      0: begin
        m_dig[0] = (m_dig[0] + 1) % 3;
        if (m_dig[0] == 2 && m_dig[1] > 3) m_dig[1] = 0;
      end
      1: m_dig[1] = (m_dig[1] + 1) % ((m_dig[0] == 2) ? 4 : 10);
      2: m_dig[2] = (m_dig[2] + 1) % 6;
      default: m_dig[3] = (m_dig[3] + 1) % 10;
    endcase
  endtask

  task automatic model_step();
    logic [5:0] lvl_old;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0;
      m_phase = 0; m_pulse = '0; m_load = 1'b0;
      foreach (m_dig[i]) m_dig[i] = 0;
      foreach (m_hist[i]) m_hist[i] = '0;
      return;
    end
    m_pulse = '0;
    m_load  = 1'b0;
    case (m_phase)
      0: begin
        for (int c = 0; c < 4; c++) if (m_press[c]) begin m_pulse[c] = 1'b1; break; end
`ifdef STOPWATCH_SET_EN
        if (m_press[4]) m_phase = 1;
`endif
      end
      1, 2, 3, 4: begin
        if (m_press[3]) m_phase = 0;
        else begin
          if (m_press[5]) model_inc(m_phase - 1);
          if (m_press[4]) begin
            m_phase++;
            if (m_phase == 5) m_pulse[0] = 1'b1;
          end
        end
      end
      5: begin m_phase = 6; m_load = 1'b1; end
      default: m_phase = 0;
    endcase
    lvl_old = m_lvl;
    for (int b = 0; b < 6; b++) begin
      m_hist[b] = {m_hist[b][D-2:0], m_s2[b]};
      if (m_hist[b] == {D{~m_lvl[b]}}) m_lvl[b] = ~m_lvl[b];
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_press = m_lvl & ~lvl_old;
  endtask

  function automatic logic [24:0] exp_vec();
    logic       mode = (m_phase >= 1 && m_phase <= 4);
    logic [1:0] sd   = mode ? 2'(m_phase - 1) : 2'd0;
    return {m_pulse, m_load, mode, sd,
            4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {sw.clr, sw.stop, sw.lap, sw.start, sw.load, sw.set_mode, sw.set_digit,
            sw.load_ms_hr, sw.load_ls_hr, sw.load_ms_min, sw.load_ls_min};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("cycle_outputs", 32'(dut_vec()), 32'(exp_vec()));
    if (sw.start) begin n_cmd[0]++; start_cyc = cyc; end
    if (sw.lap)   n_cmd[1]++;
    if (sw.stop)  n_cmd[2]++;
    if (sw.clr)   n_cmd[3]++;
    if (sw.load)  begin n_load++; load_cyc = cyc; end
  endtask

  task automatic clear_counts();
    n_cmd = '{default: 0};
    n_load = 0;
    start_cyc = -1;
    load_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_state", 32'(dut_vec()), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic pbtn(input int b);
    raw[b] = 1'b1;
    repeat (20) tick();
    raw[b] = 1'b0;
    repeat (22) tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    int   base;
    int   rem [6];

    tbl[0] = '{btns: 6'b000001, hold: 8'd40, exp: 4'b0001};
    tbl[1] = '{btns: 6'b000010, hold: 8'd10, exp: 4'b0000};
    tbl[2] = '{btns: 6'b000110, hold: 8'd30, exp: 4'b0010};
    tbl[3] = '{btns: 6'b001111, hold: 8'd30, exp: 4'b0001};
    tbl[4] = '{btns: 6'b001100, hold: 8'd30, exp: 4'b0100};
    tbl[5] = '{btns: 6'b001000, hold: 8'd15, exp: 4'b0000};
    tbl[6] = '{btns: 6'b001000, hold: 8'd16, exp: 4'b1000};
    tbl[7] = '{btns: 6'b001010, hold: 8'd20, exp: 4'b0010};

    raw = '0;
    clear_counts();
    do_reset();

    for (int i = 0; i < 8; i++) begin
      clear_counts();
      base = cyc;
      raw = tbl[i].btns;
      repeat (int'(tbl[i].hold)) tick();
      raw = '0;
      repeat (40) tick();
      for (int c = 0; c < 4; c++)
        check($sformatf("vec%0d_cmd%0d_count", i, c), n_cmd[c], {31'd0, tbl[i].exp[c]});
      if (i == 0) check("start_latency", start_cyc - base, D + 3);
    end

    // Two short lap glitches separated by a low gap must not add up to a press.
    clear_counts();
    raw[1] = 1'b1; repeat (10) tick();
    raw[1] = 1'b0; repeat (3) tick();
    raw[1] = 1'b1; repeat (10) tick();
    raw[1] = 1'b0; repeat (40) tick();
    check("lap_glitch_pair", n_cmd[1], 0);

`ifdef STOPWATCH_SET_EN
    // ls_hr = 7, then ms_hr up to 2 forces ls_hr to 0; clr aborts keeping digits.
    do_reset();
    clear_counts();
    pbtn(4); pbtn(4);
    check("edit_ls_hr_digit", sw.set_digit, 1);
    repeat (7) pbtn(5);
    check("ls_hr_is_7", sw.load_ls_hr, 7);
    pbtn(3);
    check("abort_set_mode", sw.set_mode, 0);
    pbtn(4);
    pbtn(5); pbtn(5);
    check("hr_after_clamp", {sw.load_ms_hr, sw.load_ls_hr}, 8'h20);
    pbtn(3);
    check("abort2_set_mode", sw.set_mode, 0);
    check("abort_digits_held", {sw.load_ms_hr, sw.load_ls_hr}, 8'h20);
    check("abort_no_pulses", n_cmd[0] + n_cmd[1] + n_cmd[2] + n_cmd[3] + n_load, 0);

    // Full entry of 23:59 and commit.
    do_reset();
    clear_counts();
    pbtn(4); repeat (2) pbtn(5);
    pbtn(4); repeat (3) pbtn(5);
    pbtn(4); repeat (5) pbtn(5);
    pbtn(4); repeat (9) pbtn(5);
    check("digits_2359", {sw.load_ms_hr, sw.load_ls_hr, sw.load_ms_min, sw.load_ls_min}, 16'h2359);
    pbtn(4);
    check("commit_start_count", n_cmd[0], 1);
    check("commit_load_count", n_load, 1);
    check("load_after_start", load_cyc - start_cyc, 1);
    check("commit_set_mode", sw.set_mode, 0);

    // Reset while in COMMIT_START, with set still held through reset release.
    do_reset();
    pbtn(4); pbtn(4); pbtn(4); pbtn(4);
    raw[4] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (sw.start) found = 1'b1;
    end
    check("commit_start_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_commit", 32'(dut_vec()), 32'd0);
    clear_counts();
    repeat (3) tick();
    check("no_load_after_reset", n_load, 0);
    rst_n = 1'b1;
    repeat (25) tick();
    check("held_set_press_after_reset", sw.set_mode, 1);
    raw[4] = 1'b0;
    repeat (22) tick();
`else
    // Entry buttons have no effect in this build.
    clear_counts();
    pbtn(4); pbtn(5); pbtn(4);
    check("no_set_mode", sw.set_mode, 0);
    check("no_digits", {sw.load_ms_hr, sw.load_ls_hr, sw.load_ms_min, sw.load_ls_min}, 16'h0);
    check("no_load", n_load, 0);
`endif

    // Random buttons of random hold lengths, occasional reset; model checks every cycle.
    do_reset();
    foreach (rem[b]) rem[b] = $urandom_range(1, 40);
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 6; b++) begin
        rem[b]--;
        if (rem[b] <= 0) begin
          raw[b] = ~raw[b];
          rem[b] = $urandom_range(1, 40);
        end
      end
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stopwatch_cmd_ctrl.md
# stopwatch_cmd_ctrl

Front-end controller for the BCD hour:minute stopwatch. It synchronises and debounces the raw push-buttons and turns each press into a single-cycle command pulse on the stopwatch control inputs (`start`, `lap`, `stop`, `clr`, `load`). It also runs a digit-entry sequencer that builds a valid HH:MM preset and commits it with the correct start-then-load ordering. It sits between the board pins and the stopwatch core, in the same clock domain as the core.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a debounced level changes; legal range ≥ 2.
- `DB_CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_start`, `btn_lap`, `btn_stop`, `btn_clr`  in  1 each  raw buttons, asynchronous, active high.
- `btn_set`, `btn_inc`  in  1 each  raw digit-entry buttons, asynchronous, active high.
- `start`, `lap`, `stop`, `clr`  out  1 each  registered one-cycle command pulses to the core.
- `load`  out  1  registered one-cycle load strobe to the core.
- `load_ms_hr`, `load_ls_hr`, `load_ms_min`, `load_ls_min`  out  4 each  preset digits, BCD.
- `set_mode`  out  1  high while the sequencer is in any EDIT state.
- `set_digit`  out  2  digit under edit: 0=ms_hr, 1=ls_hr, 2=ms_min, 3=ls_min.

## Operation
Buttons:
- Every button passes through a 2-flop synchroniser, then a debouncer.
- The debounced level toggles only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any mismatch-free cycle clears the counter.
- A rising edge of a debounced level produces a one-cycle internal press event. Releases produce nothing.

Command arbitration, sequencer in IDLE:
- If several press events occur in the same cycle, priority is start > lap > stop > clr. Only the winner is pulsed; the losers are discarded, not queued.
- At most one of `start`, `lap`, `stop`, `clr`, `load` is high in any cycle.

Sequencer states:
- IDLE → EDIT_MS_HR on a `set` press.
- EDIT_MS_HR → EDIT_LS_HR → EDIT_MS_MIN → EDIT_LS_MIN, advancing on each `set` press.
- EDIT_LS_MIN → COMMIT_START on a `set` press.
- COMMIT_START lasts 1 cycle and pulses `start`, then goes to COMMIT_LOAD.
- COMMIT_LOAD lasts 1 cycle and pulses `load`, then returns to IDLE.
- The order is fixed: the core samples `load` only in its RUN state, which it enters one edge after `start`.
- A `clr` press in any EDIT state aborts to IDLE. No pulse is issued and the digits are retained.
- In EDIT states, `start`, `lap` and `stop` presses are discarded.
- In COMMIT states, all presses are discarded.

Digit edit: each `inc` press increments the current digit modulo its limit.
- ms_hr: 0–2.
- ls_hr: 0–9, or 0–3 when ms_hr = 2.
- ms_min: 0–5.
- ls_min: 0–9.
- If ms_hr becomes 2 while ls_hr > 3, ls_hr is cleared to 0 in the same cycle.
- Digits are always valid BCD for the core, 00:00–23:59.
- `load_*` digits hold their value at all times except on an `inc` press.

## Timing
- Reset values: all pulses 0, `set_mode` = 0, `set_digit` = 0, all `load_*` = 0, sequencer IDLE, debounced levels 0, counters 0.
- Press latency: raw goes high before edge 0 and stays high. The debounced level rises after edge `DEBOUNCE_CYCLES`+1. The pulse is high for exactly the cycle after edge `DEBOUNCE_CYCLES`+2.
- Commit: `start` is high in the cycle after the `set` press event, `load` is high in the next cycle, and `set_mode` is 0 from COMMIT_START onward.
- `set_mode` and `set_digit` are registered and change on the same edge as the state.
- Reset asserted mid-press or mid-commit: all outputs return to reset values immediately. A button still held at release of reset produces one press once it is debounced.

## Configuration
- `STOPWATCH_SET_EN` defined: the digit-entry sequencer, the `btn_set`/`btn_inc` debouncers and the `load` path are built.
- Not defined: `btn_set` and `btn_inc` are ignored; `load`, `set_mode`, `set_digit` and all `load_*` are tied to 0. The sequencer reduces to IDLE only, and arbitration is unchanged.

## Structure
- Package `stopwatch_pkg` holds:
  - sequencer state encoding;
  - `set_digit` encoding;
  - digit limit constants (2, 9, 3, 5, 9);
  - command priority order.
- Sub-module `btn_debounce` (synchroniser plus debounce counter plus rise detect, parameterised by `DEBOUNCE_CYCLES`), one instance per button.

## Test plan
- Reset, then hold `btn_start` for 40 cycles with `DEBOUNCE_CYCLES`=16 → a single `start` pulse in the cycle after edge 18; no further pulse.
- A 10-cycle glitch on `btn_lap`, then low → no `lap` pulse; the counter clears.
- `btn_lap` and `btn_stop` pressed simultaneously → only `lap` pulses.
- Set sequence, then 2× inc at ms_hr, 3× at ls_hr, 5× at ms_min, 9× at ls_min, then set → digits 23:59; `start` then `load` on consecutive cycles.
- Preset ls_hr = 7, then inc ms_hr to 2 → ls_hr becomes 0; press clr during EDIT → IDLE, no pulses, digits held.
- `rst_n` low during COMMIT_START → no `load` pulse; all outputs at reset values.
